// File: rtl/spi_cmd_decoder_if.sv
// Byte-side and CPU-side signal bundle of the SPI command decoder.
// The slave modport is the decoder view; the master modport is the transceiver/CPU view.
interface spi_cmd_decoder_if;
    logic        cs_n;
    logic        rx_byte_ready;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [15:0] cpu_out;
    logic [15:0] cpu_in;
    logic        cmd_write;
    logic        cmd_read;
    logic        cmd_error;

    modport master (
        output cs_n,
        output rx_byte_ready,
        output rx_byte,
        output cpu_out,
        input  tx_byte,
        input  cpu_in,
        input  cmd_write,
        input  cmd_read,
        input  cmd_error
    );

    modport slave (
        input  cs_n,
        input  rx_byte_ready,
        input  rx_byte,
        input  cpu_out,
        output tx_byte,
        output cpu_in,
        output cmd_write,
        output cmd_read,
        output cmd_error
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI byte-stream command decoder: write/read/clear opcodes framed by chip select.
// Define SPI_CMD_CHECKSUM_EN to require a trailing checksum byte on write frames.
module spi_cmd_decoder #(
    parameter logic [7:0] OP_WRITE = 8'h01,
    parameter logic [7:0] OP_READ  = 8'h02,
    parameter logic [7:0] OP_CLEAR = 8'h03,
    parameter logic [7:0] IDLE_TX  = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_cmd_decoder_if.slave      bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_HI,
        ST_WR_LO,
        ST_RD_HI,
        ST_RD_LO,
`ifdef SPI_CMD_CHECKSUM_EN
        ST_DISCARD,
        ST_WR_CK
`else
        ST_DISCARD
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] shadow_q, shadow_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [15:0] cpu_in_q, cpu_in_d;
    logic        cmd_write_q, cmd_write_d;
    logic        cmd_read_q, cmd_read_d;
    logic        cmd_error_q, cmd_error_d;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]  lo_q, lo_d;
`endif

    logic byte_valid;
    logic in_write;

    assign byte_valid = bus.rx_byte_ready && !bus.cs_n;

`ifdef SPI_CMD_CHECKSUM_EN
    assign in_write = (state_q == ST_WR_HI) || (state_q == ST_WR_LO) || (state_q == ST_WR_CK);
`else
    assign in_write = (state_q == ST_WR_HI) || (state_q == ST_WR_LO);
`endif

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        shadow_d    = shadow_q;
        cpu_in_d    = cpu_in_q;
        cmd_write_d = 1'b0;
        cmd_read_d  = 1'b0;
        cmd_error_d = cmd_error_q;
`ifdef SPI_CMD_CHECKSUM_EN
        lo_d        = lo_q;
`endif

        // The CPU answers cmd_read combinationally, so capture while the strobe is high.
        if (cmd_read_q) begin
            shadow_d = bus.cpu_out;
        end

        if (bus.cs_n) begin
            state_d  = ST_IDLE;
            shadow_d = 16'h0000;
            if (in_write) begin
                cmd_error_d = 1'b1;
            end
        end else if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_byte == OP_WRITE) begin
                        state_d = ST_WR_HI;
                    end else if (bus.rx_byte == OP_READ) begin
                        state_d    = ST_RD_HI;
                        cmd_read_d = 1'b1;
                    end else if (bus.rx_byte == OP_CLEAR) begin
                        cmd_error_d = 1'b0;
                    end else if (bus.rx_byte != 8'h00) begin
                        cmd_error_d = 1'b1;
                        state_d     = ST_DISCARD;
                    end
                end
                ST_WR_HI: begin
                    hi_d    = bus.rx_byte;
                    state_d = ST_WR_LO;
                end
`ifdef SPI_CMD_CHECKSUM_EN
                ST_WR_LO: begin
                    lo_d    = bus.rx_byte;
                    state_d = ST_WR_CK;
                end
                ST_WR_CK: begin
                    if (bus.rx_byte == (hi_q ^ lo_q ^ OP_WRITE)) begin
                        cpu_in_d    = {hi_q, lo_q};
                        cmd_write_d = 1'b1;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
`else
                ST_WR_LO: begin
                    cpu_in_d    = {hi_q, bus.rx_byte};
                    cmd_write_d = 1'b1;
                    state_d     = ST_IDLE;
                end
`endif
                ST_RD_HI: state_d = ST_RD_LO;
                ST_RD_LO: state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end

        // While the read strobe is only being requested the shadow is still stale.
        tx_byte_d = IDLE_TX;
        if (!cmd_read_d) begin
            if (state_d == ST_RD_HI) begin
                tx_byte_d = shadow_d[15:8];
            end else if (state_d == ST_RD_LO) begin
                tx_byte_d = shadow_d[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hi_q        <= 8'h00;
            shadow_q    <= 16'h0000;
            tx_byte_q   <= IDLE_TX;
            cpu_in_q    <= 16'h0000;
            cmd_write_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_error_q <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
            lo_q        <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            shadow_q    <= shadow_d;
            tx_byte_q   <= tx_byte_d;
            cpu_in_q    <= cpu_in_d;
            cmd_write_q <= cmd_write_d;
            cmd_read_q  <= cmd_read_d;
            cmd_error_q <= cmd_error_d;
`ifdef SPI_CMD_CHECKSUM_EN
            lo_q        <= lo_d;
`endif
        end
    end

    assign bus.tx_byte   = tx_byte_q;
    assign bus.cpu_in    = cpu_in_q;
    assign bus.cmd_write = cmd_write_q;
    assign bus.cmd_read  = cmd_read_q;
    assign bus.cmd_error = cmd_error_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Randomized frame-level bench for spi_cmd_decoder against a positional frame parser model.
// Follows SPI_CMD_CHECKSUM_EN so the model matches the build under test.
module tb_spi_cmd_decoder;

`ifdef SPI_CMD_CHECKSUM_EN
    localparam int WR_PAYLOAD = 3;
`else
    localparam int WR_PAYLOAD = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_val;

    always #5 clk = ~clk;

    spi_cmd_decoder_if bus();

    // Garbage outside the strobe cycle exposes a mistimed capture.
    assign bus.cpu_out = bus.cmd_read ? cpu_val : ~cpu_val;

    spi_cmd_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] wr_seen[$];
    int          rd_seen;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_write) wr_seen.push_back(bus.cpu_in);
            if (bus.cmd_read)  rd_seen++;
        end
    end

    logic [7:0]  frame_q[$];
    logic [15:0] m_cpu_in;
    logic        m_err;
    int          frame_no = 0;

    // Reference: walk the frame by byte position, opcode by opcode.
    task automatic run_frame(input bit spaced, input bit tail_byte);
        logic [7:0]  exp_tx[$];
        logic [15:0] exp_wr[$];
        int          exp_rd;
        int          n;
        int          i;
        logic [7:0]  b;
        bit          ok;

        n = frame_q.size();
        exp_rd = 0;
        for (int k = 0; k < n; k++) exp_tx.push_back(8'h00);
        i = 0;
        while (i < n) begin
            b = frame_q[i];
            if (b == 8'h01) begin
                if (i + WR_PAYLOAD < n) begin
                    ok = 1'b1;
`ifdef SPI_CMD_CHECKSUM_EN
                    ok = (frame_q[i+3] == (frame_q[i+1] ^ frame_q[i+2] ^ 8'h01));
`endif
                    if (ok) begin
                        m_cpu_in = {frame_q[i+1], frame_q[i+2]};
                        exp_wr.push_back(m_cpu_in);
                    end else begin
                        m_err = 1'b1;
                    end
                    i += WR_PAYLOAD + 1;
                end else begin
                    m_err = 1'b1;
                    i = n;
                end
            end else if (b == 8'h02) begin
                exp_rd++;
                exp_tx[i] = cpu_val[15:8];
                if (i + 1 < n) exp_tx[i+1] = cpu_val[7:0];
                i += 3;
            end else if (b == 8'h03) begin
                m_err = 1'b0;
                i++;
            end else if (b == 8'h00) begin
                i++;
            end else begin
                m_err = 1'b1;
                i = n;
            end
        end

        wr_seen.delete();
        rd_seen = 0;
        @(posedge clk) #1;
        bus.cs_n = 1'b0;
        @(posedge clk) #1;
        for (int k = 0; k < n; k++) begin
            bus.rx_byte       = frame_q[k];
            bus.rx_byte_ready = 1'b1;
            @(posedge clk) #1;
            bus.rx_byte_ready = 1'b0;
            if (spaced) begin
                repeat (2) @(posedge clk);
                #1;
                check_eq($sformatf("tx f%0d b%0d", frame_no, k), bus.tx_byte, exp_tx[k]);
            end
        end
        bus.cs_n = 1'b1;
        if (tail_byte) begin
            bus.rx_byte       = 8'($urandom_range(1, 3));
            bus.rx_byte_ready = 1'b1;
            @(posedge clk) #1;
            bus.rx_byte_ready = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;

        check_eq($sformatf("wr_count f%0d", frame_no), wr_seen.size(), exp_wr.size());
        for (int k = 0; k < exp_wr.size() && k < wr_seen.size(); k++)
            check_eq($sformatf("wr_data f%0d w%0d", frame_no, k), wr_seen[k], exp_wr[k]);
        check_eq($sformatf("rd_count f%0d", frame_no), rd_seen, exp_rd);
        check_eq($sformatf("cpu_in f%0d", frame_no), bus.cpu_in, m_cpu_in);
        check_eq($sformatf("cmd_error f%0d", frame_no), bus.cmd_error, m_err);
        check_eq($sformatf("tx_idle f%0d", frame_no), bus.tx_byte, 8'h00);
        $display("frame %0d: %0d bytes spaced=%0d tail=%0d writes=%0d reads=%0d err=%0d",
                 frame_no, n, spaced, tail_byte, exp_wr.size(), exp_rd, m_err);
        frame_no++;
    endtask

    task automatic add_write(input logic [7:0] hi, input logic [7:0] lo, input bit good);
        frame_q.push_back(8'h01);
        frame_q.push_back(hi);
        frame_q.push_back(lo);
`ifdef SPI_CMD_CHECKSUM_EN
        frame_q.push_back(good ? (hi ^ lo ^ 8'h01) : (hi ^ lo ^ 8'h01 ^ 8'($urandom_range(1, 255))));
`else
        if (!good) frame_q.push_back(8'h00);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, " tx"},        bus.tx_byte,   8'h00);
        check_eq({tag, " cpu_in"},    bus.cpu_in,    16'h0000);
        check_eq({tag, " cmd_write"}, bus.cmd_write, 1'b0);
        check_eq({tag, " cmd_read"},  bus.cmd_read,  1'b0);
        check_eq({tag, " cmd_error"}, bus.cmd_error, 1'b0);
    endtask

    initial begin
        int   ncmd;
        int   r;
        logic [7:0] bad;

        rst               = 1'b1;
        bus.cs_n          = 1'b1;
        bus.rx_byte_ready = 1'b0;
        bus.rx_byte       = 8'h00;
        cpu_val           = 16'h0000;
        m_cpu_in          = 16'h0000;
        m_err             = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk) #1;
        check_reset_values("reset");

        frame_q = '{8'h01, 8'h12, 8'h34};
`ifdef SPI_CMD_CHECKSUM_EN
        frame_q.push_back(8'h27);
`endif
        run_frame(1'b1, 1'b0);

        cpu_val = 16'hBEEF;
        frame_q = '{8'h02, 8'h55, 8'hAA};
        run_frame(1'b1, 1'b0);

        frame_q = '{8'h7F, 8'h01, 8'h12, 8'h34};
        run_frame(1'b1, 1'b0);
        frame_q = '{8'h03};
        run_frame(1'b1, 1'b0);

        frame_q = '{8'h01, 8'h12};
        run_frame(1'b1, 1'b0);
        frame_q.delete();
        add_write(8'hAB, 8'hCD, 1'b1);
        run_frame(1'b1, 1'b0);

`ifdef SPI_CMD_CHECKSUM_EN
        frame_q = '{8'h01, 8'h12, 8'h34, 8'h00};
        run_frame(1'b1, 1'b0);
`endif

        // Reset in the middle of a write frame, chip select still low.
        @(posedge clk) #1;
        bus.cs_n = 1'b0;
        foreach (frame_q[k]) frame_q[k] = 8'h00;
        frame_q = '{8'h01, 8'h12};
        for (int k = 0; k < 2; k++) begin
            bus.rx_byte       = frame_q[k];
            bus.rx_byte_ready = 1'b1;
            @(posedge clk) #1;
            bus.rx_byte_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        check_reset_values("midreset");
        bus.cs_n = 1'b1;
        m_cpu_in = 16'h0000;
        m_err    = 1'b0;
        frame_q = '{8'h12, 8'h34};
        run_frame(1'b1, 1'b0);

        for (int f = 0; f < 150; f++) begin
            frame_q.delete();
            cpu_val = 16'($urandom);
            ncmd = $urandom_range(1, 3);
            for (int c = 0; c < ncmd; c++) begin
                r = $urandom_range(0, 7);
                case (r)
                    0, 1: add_write(8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
                    2, 3: begin
                        frame_q.push_back(8'h02);
                        frame_q.push_back(8'($urandom));
                        frame_q.push_back(8'($urandom));
                    end
                    4: frame_q.push_back(8'h03);
                    5: frame_q.push_back(8'h00);
                    6: begin
                        bad = 8'($urandom_range(4, 255));
                        frame_q.push_back(bad);
                    end
                    default: frame_q.push_back(8'($urandom));
                endcase
            end
            if ($urandom_range(0, 9) < 3 && frame_q.size() > 1) begin
                r = $urandom_range(1, frame_q.size() - 1);
                while (frame_q.size() > r) void'(frame_q.pop_back());
            end
            run_frame($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
